mux_bbbb: RTL and testbench
===========================

// Module: mux_bbbb
//
// PURPOSE
// - Boolean 2:1 select primitive: y = cond ? t : f, all operands 1-bit booleans.
// - Leaf cell in the generated datapath library, instantiated wherever a boolean
//   "mux" instruction is lowered.
// - Default build is purely combinational. An optional output register is kept
//   for timing-closure variants.
//
// PARAMETERS
// - WIDTH    1  data width of t, f and y; the default boolean form uses 1.
// - OUT_REG  0  0 = combinational output; 1 = one-cycle registered output.
// - RST_VAL  0  value loaded into the output register on reset (OUT_REG=1 only).
//
// PORTS
// - clock  in   1      single clock; all state is on the rising edge.
// - reset  in   1      synchronous, active-low reset; sampled on the rising edge of clock.
// - cond   in   1      select: 1 -> t, 0 -> f.
// - t      in   WIDTH  value driven when cond=1.
// - f      in   WIDTH  value driven when cond=0.
// - y      out  WIDTH  selected value; zero-extended by the consumer if its net is wider.
//
// BEHAVIOUR
// - OUT_REG=0 (default):
//   - y = cond ? t : f, continuously, with zero latency.
//   - Output is independent of clock and reset; reset does not force y.
//   - Any input change is visible on y within the same cycle; glitch-free
//     behaviour is not required.
// - OUT_REG=1:
//   - y_q <= cond ? t : f on each rising edge; latency is 1 cycle.
//   - reset==0 at an edge forces y_q to RST_VAL; reset has priority over data.
//   - On the first edge with reset==1, y_q loads the current selection.
//   - Reset asserted mid-stream discards the in-flight value at that edge.
// - X/undefined cond must not propagate as a silent choice. In simulation,
//   cond===1'bx drives y to all-X.
// - No handshake, no state machine, no arithmetic.
// - When t==f, y equals that value regardless of cond.
//
// STRUCTURE
// - Shared package mux_pkg:
//   - localparam constants SEL_T=1'b1 and SEL_F=1'b0.
//   - Default WIDTH constant.
// - Core: one continuous-assign select.
// - Optional sub-module mux_out_reg: WIDTH-wide D flop with sync active-low
//   reset to RST_VAL. Instantiated under generate only when OUT_REG=1.
// - No other hierarchy.
//
// TESTING (default params, combinational)
// - cond=0,t=1,f=0 -> y=0 in the same cycle.
// - cond=1,t=1,f=0 -> y=1 in the same cycle; step from the previous vector
//   shows y 0->1 with no clock-edge delay.
// - Exhaustive 8 vectors of {cond,t,f} -> y matches cond?t:f every vector,
//   including t==f cases (y=t).
// - Hold reset=0 with cond=1,t=1,f=0 -> y=1; reset does not affect the
//   combinational path.
// - OUT_REG=1, RST_VAL=0:
//   - reset=0 for 2 cycles -> y=0.
//   - Release reset with cond=1,t=1 -> y=1 exactly one edge later.
//   - Reassert reset -> y=0 at the next edge.
// - OUT_REG=0, WIDTH=8: t=8'hA5, f=8'h3C; toggle cond -> y alternates A5/3C
//   with zero latency.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the boolean select primitive.
//   SEL_T / SEL_F : cond values that pick t / f.
//   DEFAULT_WIDTH : data width of the plain boolean form.
package mux_pkg;
   localparam logic        SEL_T         = 1'b1;
   localparam logic        SEL_F         = 1'b0;
   localparam int unsigned DEFAULT_WIDTH = 1;
endpackage

// File: rtl/mux_out_reg.sv
// Optional output register for timing-closure variants of mux_bbbb.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-low reset, loads RST_VAL (priority over d_i)
//   d_i   : next value
//   q_o   : registered value, one cycle behind d_i
module mux_out_reg
   import mux_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] y_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         y_q <= RST_VAL;
      end else begin
         y_q <= d_i;
      end
   end

   assign q_o = y_q;

endmodule

// File: rtl/mux_bbbb.sv
// Boolean 2:1 select leaf cell: y = cond ? t : f.
// Ports:
//   clock, reset : only used when OUT_REG=1 (reset is sync, active-low)
//   cond         : select, 1 -> t, 0 -> f
//   t, f         : WIDTH-bit data operands
//   y            : selected value (combinational, or registered when OUT_REG=1)
module mux_bbbb
   import mux_pkg::*;
#(
   parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
   parameter bit               OUT_REG = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cond,
   input  logic [WIDTH-1:0] t,
   input  logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] sel_d;

   // An unknown cond falls through both compares and yields all-X, so a bad
   // select is visible in simulation instead of silently choosing f.
   // Synthesis treats the X leg as don't-care.
   assign sel_d = (cond == SEL_T) ? t : ((cond == SEL_F) ? f : {WIDTH{1'bx}});

   generate
      if (OUT_REG) begin : g_reg
         mux_out_reg #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
         ) u_out_reg (
            .clock (clock),
            .reset (reset),
            .d_i   (sel_d),
            .q_o   (y)
         );
      end else begin : g_comb
         // Clock and reset have no role in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clock ^ reset;
         assign y = sel_d;
      end
   endgenerate

endmodule

// File: tb/tb_mux_bbbb.sv
module tb_mux_bbbb;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       cond1 = 1'b0;
   logic       t1    = 1'b0;
   logic       f1    = 1'b0;
   logic       cond8 = 1'b0;
   logic [7:0] t8    = 8'h00;
   logic [7:0] f8    = 8'h00;

   logic       y_comb1;
   logic       y_reg1;
   logic [7:0] y_comb8;
   logic [7:0] y_reg8;

   localparam logic [7:0] RST8 = 8'h5A;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   mux_bbbb u_comb1 (
      .clock (clock), .reset (reset), .cond (cond1), .t (t1), .f (f1), .y (y_comb1)
   );

   mux_bbbb #(.WIDTH(1), .OUT_REG(1'b1), .RST_VAL(1'b0)) u_reg1 (
      .clock (clock), .reset (reset), .cond (cond1), .t (t1), .f (f1), .y (y_reg1)
   );

   mux_bbbb #(.WIDTH(8), .OUT_REG(1'b0)) u_comb8 (
      .clock (clock), .reset (reset), .cond (cond8), .t (t8), .f (f8), .y (y_comb8)
   );

   mux_bbbb #(.WIDTH(8), .OUT_REG(1'b1), .RST_VAL(RST8)) u_reg8 (
      .clock (clock), .reset (reset), .cond (cond8), .t (t8), .f (f8), .y (y_reg8)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic c;
      logic tv;
      logic fv;
      logic y;
   } vec_t;

   vec_t vecs[8];

   // Reference: select by masking, independent of the RTL's structure.
   function automatic logic [7:0] ref_sel(input logic c, input logic [7:0] tv, input logic [7:0] fv);
      logic [7:0] m;
      m = c ? 8'hFF : 8'h00;
      return (tv & m) | (fv & ~m);
   endfunction

   initial begin
      logic       exp_r1;
      logic [7:0] exp_r8;
      logic       rs;

      // cond, t, f -> y, worked by hand
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

      // Exhaustive table, once with reset held low and once released:
      // the combinational path must ignore reset.
      for (int r = 0; r < 2; r++) begin
         @(negedge clock);
         reset = (r == 1);
         for (int i = 0; i < 8; i++) begin
            cond1 = vecs[i].c;
            t1    = vecs[i].tv;
            f1    = vecs[i].fv;
            #1;
            check($sformatf("table r=%0d v=%0d", r, i), {7'd0, y_comb1}, {7'd0, vecs[i].y});
         end
      end

      // Zero-latency step 0 -> 1 mid-cycle, no clock edge in between.
      @(posedge clock); #1;
      cond1 = 1'b0; t1 = 1'b1; f1 = 1'b0;
      #1;
      check("step before", {7'd0, y_comb1}, 8'd0);
      cond1 = 1'b1;
      #1;
      check("step after", {7'd0, y_comb1}, 8'd1);

      // Registered variant: reset for 2 cycles, release, reassert.
      @(negedge clock);
      reset = 1'b0; cond1 = 1'b1; t1 = 1'b1; f1 = 1'b0;
      cond8 = 1'b1; t8 = 8'hC3; f8 = 8'h11;
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         check($sformatf("reg1 in reset %0d", k), {7'd0, y_reg1}, 8'd0);
         check($sformatf("reg8 in reset %0d", k), y_reg8, RST8);
      end
      check("comb1 under reset", {7'd0, y_comb1}, 8'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("reg1 before first edge", {7'd0, y_reg1}, 8'd0);
      @(posedge clock); #1;
      check("reg1 one edge after release", {7'd0, y_reg1}, 8'd1);
      check("reg8 one edge after release", y_reg8, 8'hC3);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("reg1 before reassert edge", {7'd0, y_reg1}, 8'd1);
      @(posedge clock); #1;
      check("reg1 reassert", {7'd0, y_reg1}, 8'd0);
      check("reg8 reassert", y_reg8, RST8);

      // Wide combinational: alternating A5/3C on cond toggles.
      @(negedge clock);
      reset = 1'b1; t8 = 8'hA5; f8 = 8'h3C;
      for (int k = 0; k < 4; k++) begin
         cond8 = k[0];
         #1;
         check($sformatf("w8 toggle %0d", k), y_comb8, k[0] ? 8'hA5 : 8'h3C);
      end

      // Randomized: comb outputs against the masking model, registered
      // outputs against the value predicted one edge ahead.
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         rs    = ($urandom_range(0, 7) != 0);
         reset = rs;
         cond1 = 1'($urandom_range(0, 1));
         t1    = 1'($urandom_range(0, 1));
         f1    = 1'($urandom_range(0, 1));
         cond8 = 1'($urandom_range(0, 1));
         t8    = 8'($urandom);
         f8    = (n % 5 == 0) ? t8 : 8'($urandom);
         exp_r1 = rs ? ref_sel(cond1, {7'd0, t1}, {7'd0, f1}) != 8'd0 : 1'b0;
         exp_r8 = rs ? ref_sel(cond8, t8, f8) : RST8;
         #1;
         check("rand comb1", {7'd0, y_comb1}, ref_sel(cond1, {7'd0, t1}, {7'd0, f1}));
         check("rand comb8", y_comb8, ref_sel(cond8, t8, f8));
         @(posedge clock); #1;
         check("rand reg1", {7'd0, y_reg1}, {7'd0, exp_r1});
         check("rand reg8", y_reg8, exp_r8);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
